// File: rtl/bert_pkg.sv
// rtl/bert_pkg.sv - shared BERT defaults, FSM state encoding and PRBS8 generator step
package bert_pkg;

    localparam int LOCK_CNT_DEF = 16;
    localparam int WIN_DEF      = 64;
    localparam int LOSS_THR_DEF = 8;
    localparam int ERR_W_DEF    = 32;
    localparam int BIT_W_DEF    = 48;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // One step of the transmit generator; its output bit is q[7] before the step.
    function automatic logic [7:0] prbs8_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[6]};
    endfunction

endpackage

// File: rtl/bert_loss_window.sv
// rtl/bert_loss_window.sv - sliding loss-of-lock window: counts errors per WIN valid bits
module bert_loss_window
    import bert_pkg::*;
#(
    parameter int WIN      = WIN_DEF,
    parameter int LOSS_THR = LOSS_THR_DEF
) (
    input  logic clk320,
    input  logic rstb,
    input  logic en,
    input  logic err,
    input  logic clear,
    output logic loss
);

    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(LOSS_THR + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);
    localparam logic [EW-1:0] THR_LAST = EW'(LOSS_THR - 1);

    logic [CW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    // Loss fires on the same edge that would register the threshold-th error.
    assign loss = en && err && (win_err == THR_LAST);

    always_ff @(posedge clk320 or negedge rstb) begin
        if (!rstb) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (clear || loss) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (en) begin
            if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (err) win_err <= win_err + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prbs8_checker.sv
// rtl/prbs8_checker.sv - PRBS8 bit-error checker with lock FSM, saturating counters and stuck-zero detect
module prbs8_checker
    import bert_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int WIN      = WIN_DEF,
    parameter int LOSS_THR = LOSS_THR_DEF,
    parameter int ERR_W    = ERR_W_DEF,
    parameter int BIT_W    = BIT_W_DEF
) (
    input  logic             clk320,
    input  logic             rstb,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic [7:0]       lock_loss_cnt,
    output logic             stuck_zero
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);

    state_t        state;
    logic [7:0]    hist;
    logic [7:0]    raw;
    logic [3:0]    fill;
    logic [3:0]    raw_fill;
    logic [MW-1:0] match;
    logic          pred;
    logic          mismatch;
    logic          in_lock;
    logic          filled;
    logic          loss;
    logic          drop;

    assign pred       = hist[7] ^ hist[6];
    assign mismatch   = bit_in ^ pred;
    assign in_lock    = (state == LOCKED);
    assign filled     = (fill == 4'd8);
    assign stuck_zero = (raw_fill == 4'd8) && (raw == 8'h00);
    assign drop       = in_lock && (loss || stuck_zero);
    assign locked     = in_lock;

    bert_loss_window #(
        .WIN      (WIN),
        .LOSS_THR (LOSS_THR)
    ) u_win (
        .clk320 (clk320),
        .rstb   (rstb),
        .en     (bit_vld && in_lock),
        .err    (mismatch),
        .clear  (!in_lock),
        .loss   (loss)
    );

    always_ff @(posedge clk320 or negedge rstb) begin
        if (!rstb) begin
            state     <= HUNT;
            hist      <= 8'h00;
            raw       <= 8'h00;
            fill      <= 4'd0;
            raw_fill  <= 4'd0;
            match     <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_vld) begin
                raw <= {raw[6:0], bit_in};
                if (raw_fill != 4'd8) raw_fill <= raw_fill + 1'b1;
                if (in_lock) begin
                    // Free-running: feed back the prediction so one flipped bit costs one error.
                    hist      <= {hist[6:0], pred};
                    err_pulse <= mismatch;
                    if (drop) begin
                        state <= HUNT;
                        fill  <= 4'd0;
                        match <= '0;
                    end
                end else begin
                    hist <= {hist[6:0], bit_in};
                    if (!filled) begin
                        fill <= fill + 1'b1;
                    end else if ((hist == 8'h00) || mismatch) begin
                        match <= '0;
                    end else if (match == MATCH_LAST) begin
                        match <= '0;
                        state <= LOCKED;
                    end else begin
                        match <= match + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk320 or negedge rstb) begin
        if (!rstb) begin
            err_cnt       <= '0;
            bit_cnt       <= '0;
            lock_loss_cnt <= 8'h00;
        end else begin
            if (clr)
                err_cnt <= '0;
            else if (bit_vld && in_lock && mismatch && (err_cnt != {ERR_W{1'b1}}))
                err_cnt <= err_cnt + 1'b1;

            if (clr)
                bit_cnt <= '0;
            else if (bit_vld && in_lock && (bit_cnt != {BIT_W{1'b1}}))
                bit_cnt <= bit_cnt + 1'b1;

            if (clr)
                lock_loss_cnt <= 8'h00;
            else if (bit_vld && drop && (lock_loss_cnt != 8'hFF))
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prbs8_checker.sv
// tb/tb_prbs8_checker.sv - scenario and randomized checks of prbs8_checker against a queue-based model
module tb_prbs8_checker;
    import bert_pkg::*;

    localparam int ERR_W = ERR_W_DEF;
    localparam int BIT_W = BIT_W_DEF;
    localparam longint ERR_MAX = (longint'(1) << ERR_W) - 1;
    localparam longint BIT_MAX = (longint'(1) << BIT_W) - 1;

    logic             clk320 = 1'b0;
    logic             rstb;
    logic             bit_in;
    logic             bit_vld;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       lock_loss_cnt;
    logic             stuck_zero;

    int total = 0;
    int bad   = 0;
    logic [7:0] g;

    int     m_locked, m_fill, m_run, m_wpos, m_werr, m_pulse, m_stuck, m_loss;
    longint m_err, m_bits;
    int     ref_q[$];
    int     raw_q[$];

    prbs8_checker dut (
        .clk320        (clk320),
        .rstb          (rstb),
        .bit_in        (bit_in),
        .bit_vld       (bit_vld),
        .clr           (clr),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_cnt       (err_cnt),
        .bit_cnt       (bit_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .stuck_zero    (stuck_zero)
    );

    always #5 clk320 = ~clk320;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic gen_bit();
        logic b;
        b = g[7];
        g = prbs8_next(g);
        return b;
    endfunction

    function automatic void model_reset();
        m_locked = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
        m_pulse = 0; m_stuck = 0; m_loss = 0; m_err = 0; m_bits = 0;
        ref_q.delete();
        raw_q.delete();
    endfunction

    // Reference: s[n] = s[n-8] ^ s[n-7] over the last eight reference bits (oldest first).
    function automatic void model_step(input logic b, input logic v, input logic c);
        int pred, e, drop;
        m_pulse = 0;
        if (v) begin
            pred = (ref_q.size() == 8) ? (ref_q[0] ^ ref_q[1]) : 0;
            if (m_locked != 0) begin
                e    = (int'(b) != pred) ? 1 : 0;
                drop = m_stuck;
                ref_q.push_back(pred);
                void'(ref_q.pop_front());
                if (m_bits < BIT_MAX) m_bits++;
                if (e != 0 && m_err < ERR_MAX) m_err++;
                m_pulse = e;
                m_werr += e;
                if (m_werr >= LOSS_THR_DEF) drop = 1;
                else begin
                    m_wpos++;
                    if (m_wpos == WIN_DEF) begin m_wpos = 0; m_werr = 0; end
                end
                if (drop != 0) begin
                    m_locked = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
                    if (m_loss < 255) m_loss++;
                    ref_q.delete();
                end
            end else if (m_fill < 8) begin
                ref_q.push_back(int'(b));
                m_fill++;
            end else begin
                if (ref_q.sum() == 0 || int'(b) != pred) m_run = 0;
                else m_run++;
                ref_q.push_back(int'(b));
                void'(ref_q.pop_front());
                if (m_run == LOCK_CNT_DEF) begin
                    m_locked = 1; m_run = 0; m_wpos = 0; m_werr = 0;
                end
            end
            raw_q.push_back(int'(b));
            if (raw_q.size() > 8) void'(raw_q.pop_front());
            m_stuck = (raw_q.size() == 8 && raw_q.sum() == 0) ? 1 : 0;
        end
        if (c) begin m_err = 0; m_bits = 0; m_loss = 0; end
    endfunction

    task automatic step(input logic b, input logic v, input logic c);
        bit_in = b; bit_vld = v; clr = c;
        @(posedge clk320);
        model_step(b, v, c);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0; bit_vld = 1'b0; bit_in = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk320);
        #1 rstb = 1'b1;
    endtask

    task automatic acquire(output int n);
        n = 0;
        while (locked !== 1'b1 && n < 100) begin
            step(gen_bit(), 1'b1, 1'b0);
            n++;
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; bit_vld = 1'b0; bit_in = 1'b0; clr = 1'b0;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (bit_cnt !== '0) begin bad++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
        total++; if (lock_loss_cnt !== 8'h00) begin bad++; $display("FAIL reset_lock_loss got=%0d exp=0", lock_loss_cnt); end
        total++; if (stuck_zero !== 1'b0) begin bad++; $display("FAIL reset_stuck_zero got=%b exp=0", stuck_zero); end
        do_reset();
    endtask

    task automatic test_clean();
        int n;
        do_reset(); g = 8'h01;
        acquire(n);
        total++; if (n != 24) begin bad++; $display("FAIL clean_lock_bits got=%0d exp=24", n); end
        repeat (1000) step(gen_bit(), 1'b1, 1'b0);
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (bit_cnt !== BIT_W'(1000)) begin bad++; $display("FAIL clean_bit_cnt got=%0d exp=1000", bit_cnt); end
        total++; if (lock_loss_cnt !== 8'h00) begin bad++; $display("FAIL clean_lock_loss got=%0d exp=0", lock_loss_cnt); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_locked got=%b exp=1", locked); end
    endtask

    task automatic test_single_error();
        int n, pulses;
        logic b;
        do_reset(); g = 8'h01;
        acquire(n);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            b = gen_bit();
            if (i == 100) b = ~b;
            step(b, 1'b1, 1'b0);
            if (err_pulse === 1'b1) pulses++;
            total++;
            if (err_pulse !== (i == 100)) begin
                bad++; $display("FAIL single_err_pulse bit=%0d got=%b exp=%b", i, err_pulse, (i == 100));
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL single_pulse_count got=%0d exp=1", pulses); end
        total++; if (err_cnt !== ERR_W'(1)) begin bad++; $display("FAIL single_err_cnt got=%0d exp=1", err_cnt); end
        total++; if (bit_cnt !== BIT_W'(200)) begin bad++; $display("FAIL single_bit_cnt got=%0d exp=200", bit_cnt); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL single_locked got=%b exp=1", locked); end
    endtask

    task automatic test_burst();
        int n;
        do_reset(); g = 8'h01;
        acquire(n);
        repeat (10) step(gen_bit(), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(~gen_bit(), 1'b1, 1'b0);
            total++;
            if (locked !== (i < 7)) begin
                bad++; $display("FAIL burst_locked err=%0d got=%b exp=%b", i + 1, locked, (i < 7));
            end
        end
        total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL burst_lock_loss got=%0d exp=1", lock_loss_cnt); end
        total++; if (err_cnt !== ERR_W'(8)) begin bad++; $display("FAIL burst_err_cnt got=%0d exp=8", err_cnt); end
        acquire(n);
        total++; if (n != 24) begin bad++; $display("FAIL burst_relock_bits got=%0d exp=24", n); end
        total++; if (err_cnt !== ERR_W'(8)) begin bad++; $display("FAIL burst_err_hold got=%0d exp=8", err_cnt); end
    endtask

    task automatic test_stuck_zero();
        int n;
        logic b;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i < 8) begin
                total++;
                if (stuck_zero !== (i == 7)) begin
                    bad++; $display("FAIL zero_stuck bit=%0d got=%b exp=%b", i, stuck_zero, (i == 7));
                end
            end
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL zero_locked bit=%0d got=%b exp=0", i, locked); end
        end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL zero_err_cnt got=%0d exp=0", err_cnt); end

        do_reset(); g = 8'h01;
        acquire(n);
        repeat (20) step(gen_bit(), 1'b1, 1'b0);
        repeat (8) begin b = gen_bit(); step(1'b0, 1'b1, 1'b0); end
        step(gen_bit(), 1'b1, 1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL zero_burst_locked got=%b exp=0", locked); end
        total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL zero_burst_loss got=%0d exp=1", lock_loss_cnt); end
        total++; if (err_cnt !== m_err[ERR_W-1:0]) begin bad++; $display("FAIL zero_burst_err got=%0d exp=%0d", err_cnt, m_err); end

        for (int k = 0; k < 260; k++) begin
            acquire(n);
            repeat (8) begin b = gen_bit(); step(1'b0, 1'b1, 1'b0); end
            step(gen_bit(), 1'b1, 1'b0);
        end
        total++; if (lock_loss_cnt !== 8'hFF) begin bad++; $display("FAIL loss_saturate got=%0d exp=255", lock_loss_cnt); end
        total++; if (lock_loss_cnt !== 8'(m_loss)) begin bad++; $display("FAIL loss_model got=%0d exp=%0d", lock_loss_cnt, m_loss); end
    endtask

    task automatic test_clr();
        int n;
        do_reset(); g = 8'h01;
        acquire(n);
        repeat (20) step(gen_bit(), 1'b1, 1'b0);
        step(~gen_bit(), 1'b1, 1'b1);
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (bit_cnt !== '0) begin bad++; $display("FAIL clr_bit_cnt got=%0d exp=0", bit_cnt); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_locked got=%b exp=1", locked); end
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL clr_err_pulse got=%b exp=1", err_pulse); end
        repeat (5) step(gen_bit(), 1'b1, 1'b0);
        step(~gen_bit(), 1'b1, 1'b0);
        total++; if (err_cnt !== ERR_W'(1)) begin bad++; $display("FAIL clr_next_err got=%0d exp=1", err_cnt); end
        total++; if (bit_cnt !== BIT_W'(6)) begin bad++; $display("FAIL clr_next_bits got=%0d exp=6", bit_cnt); end
    endtask

    task automatic test_reset_mid_lock();
        int n;
        do_reset(); g = 8'h01;
        acquire(n);
        repeat (30) step(gen_bit(), 1'b1, 1'b0);
        step(~gen_bit(), 1'b1, 1'b0);
        bit_vld = 1'b0;
        #2 rstb = 1'b0;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_rst_locked got=%b exp=0", locked); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_err_pulse got=%b exp=0", err_pulse); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL mid_rst_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (bit_cnt !== '0) begin bad++; $display("FAIL mid_rst_bit_cnt got=%0d exp=0", bit_cnt); end
        model_reset();
        @(posedge clk320);
        #1 rstb = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        total++; if (stuck_zero !== 1'b0 || locked !== 1'b0) begin
            bad++; $display("FAIL mid_rst_idle got=%b%b exp=00", stuck_zero, locked);
        end
        g = 8'h01;
        acquire(n);
        total++; if (n != 24) begin bad++; $display("FAIL mid_rst_relock got=%0d exp=24", n); end
    endtask

    task automatic test_vld_gaps();
        int n;
        do_reset(); g = 8'h01; n = 0;
        for (int k = 0; locked !== 1'b1 && k < 200; k++) begin
            if (k % 2 == 0) begin step(gen_bit(), 1'b1, 1'b0); n++; end
            else step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        total++; if (n != 24) begin bad++; $display("FAIL gaps_lock_bits got=%0d exp=24", n); end
        for (int k = 0; k < 2000; k++) begin
            if (k % 2 == 0) step(gen_bit(), 1'b1, 1'b0);
            else step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        total++; if (bit_cnt !== BIT_W'(1000)) begin bad++; $display("FAIL gaps_bit_cnt got=%0d exp=1000", bit_cnt); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL gaps_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (lock_loss_cnt !== 8'h00) begin bad++; $display("FAIL gaps_lock_loss got=%0d exp=0", lock_loss_cnt); end
    endtask

    task automatic test_random();
        int burst, zburst;
        logic v, b, c;
        do_reset(); g = 8'h01; burst = 0; zburst = 0;
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 299) == 0);
            if (v) begin
                if (burst == 0 && zburst == 0) begin
                    if ($urandom_range(0, 199) == 0) burst = $urandom_range(1, 10);
                    else if ($urandom_range(0, 399) == 0) zburst = 9;
                end
                b = gen_bit();
                if (zburst > 0) begin b = 1'b0; zburst--; end
                else if (burst > 0) begin b = ~b; burst--; end
                else if ($urandom_range(0, 99) == 0) b = ~b;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(b, v, c);
            total++; if (locked !== (m_locked != 0)) begin bad++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%0d", i, locked, m_locked); end
            total++; if (err_pulse !== (m_pulse != 0)) begin bad++; $display("FAIL rnd_err_pulse cyc=%0d got=%b exp=%0d", i, err_pulse, m_pulse); end
            total++; if (err_cnt !== m_err[ERR_W-1:0]) begin bad++; $display("FAIL rnd_err_cnt cyc=%0d got=%0d exp=%0d", i, err_cnt, m_err); end
            total++; if (bit_cnt !== m_bits[BIT_W-1:0]) begin bad++; $display("FAIL rnd_bit_cnt cyc=%0d got=%0d exp=%0d", i, bit_cnt, m_bits); end
            total++; if (lock_loss_cnt !== 8'(m_loss)) begin bad++; $display("FAIL rnd_lock_loss cyc=%0d got=%0d exp=%0d", i, lock_loss_cnt, m_loss); end
            total++; if (stuck_zero !== (m_stuck != 0)) begin bad++; $display("FAIL rnd_stuck_zero cyc=%0d got=%b exp=%0d", i, stuck_zero, m_stuck); end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_burst();
        test_stuck_zero();
        test_clr();
        test_reset_mid_lock();
        test_vld_gaps();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs8_checker.md
PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive matching valid bits in HUNT required to assert lock.
REQ-002 Parameter WIN, default 64: length of the loss-of-lock window, in valid bits.
REQ-003 Parameter LOSS_THR, default 8: errors within one window that force loss of lock.
REQ-004 Parameter ERR_W, default 32: width of err_cnt.
REQ-005 Parameter BIT_W, default 48: width of bit_cnt.
REQ-006 clk320  in  1  320 MHz bit clock; one clock for the whole block; all flops on rising edge.
REQ-007 rstb  in  1  reset, asynchronous assert, active-low.
REQ-008 bit_in  in  1  received serial bit; sampled only when bit_vld=1.
REQ-009 bit_vld  in  1  qualifies bit_in; when 0, all state holds.
REQ-010 clr  in  1  synchronous clear of err_cnt, bit_cnt and lock_loss_cnt.
REQ-011 locked  out  1  checker is in the LOCKED state.
REQ-012 err_pulse  out  1  one-cycle pulse per mismatched bit in LOCKED.
REQ-013 err_cnt  out  ERR_W  saturating count of errors while LOCKED.
REQ-014 bit_cnt  out  BIT_W  saturating count of valid bits checked while LOCKED.
REQ-015 lock_loss_cnt  out  8  saturating count of LOCKED->HUNT transitions.
REQ-016 stuck_zero  out  1  the eight most recent received bits are all 0.

Function
REQ-017 Reference sequence: s[n] = s[n-8] XOR s[n-7]. This is the sequence produced by the 8-bit generator {q[6:0], q[7]^q[6]} with output q[7].
REQ-018 History register hist[7:0]: hist[0] is the newest bit; each valid bit shifts into hist[0]. The prediction is pred = hist[7] XOR hist[6].
REQ-019 The FSM has two states, HUNT and LOCKED; the reset state is HUNT.
REQ-020 HUNT, history loading: hist loads bit_in on each valid bit. A fill counter counts the first 8 valid bits after entering HUNT; no compares are made until fill reaches 8.
REQ-021 HUNT, lock acquisition:
- After fill, each valid bit compares bit_in against pred.
- A match increments the match counter.
- A mismatch clears the match counter to 0.
- A valid bit while hist equals 0x00 also clears the match counter to 0 and does not count as a match.
REQ-022 HUNT->LOCKED occurs on the edge that registers the LOCK_CNT-th consecutive match; locked is 1 from that edge.
REQ-023 LOCKED, history update: hist loads pred, not bit_in. The checker free-runs, so one flipped input bit produces exactly one error.
REQ-024 LOCKED, per-valid-bit counting:
- bit_cnt increments by 1 on every valid bit.
- On bit_in != pred, err_cnt increments by 1 and err_pulse is 1 on the next cycle only (1-cycle latency).
REQ-025 Loss window: a window counter counts valid bits from 0 to WIN-1 and then wraps. Errors in the current window are counted; both counters clear on wrap and on entry to LOCKED.
REQ-026 LOCKED->HUNT occurs when the window error count reaches LOSS_THR. On that edge:
- lock_loss_cnt increments.
- fill, match, window and window error counters clear.
- err_cnt and bit_cnt hold their values.
REQ-027 stuck_zero is derived from a separate raw shift register of bit_in, updated on every valid bit in both states. It is 1 when that register equals 0x00 after at least 8 valid bits since reset.
REQ-028 stuck_zero=1 while LOCKED forces LOCKED->HUNT on the next edge and counts as a lock loss.
REQ-029 Saturation: err_cnt, bit_cnt and lock_loss_cnt stop at their all-ones value and never wrap.
REQ-030 clr has priority over a simultaneous increment: the counter is 0 on the next cycle. clr does not affect the FSM, hist, window logic or locked.
REQ-031 When bit_vld=0, err_pulse is 0 and no counter, hist or state changes.

Reset
REQ-032 rstb=0 asynchronously sets:
- state=HUNT, locked=0, err_pulse=0, stuck_zero=0.
- err_cnt=0, bit_cnt=0, lock_loss_cnt=0.
- hist=0x00, raw shift register=0x00.
- all internal counters=0.
REQ-033 Reset deassertion mid-stream restarts acquisition from HUNT with fill=0; no output changes until the first valid bit after reset.

Structure
REQ-034 A shared package bert_pkg holds the default parameter values and the state encoding constants HUNT=1'b0 and LOCKED=1'b1. The transmitter and the bench use the same package.
REQ-035 One sub-module, bert_loss_window, holds the window counter, the window error counter and the threshold compare. Its output is a single loss pulse; everything else sits in prbs8_checker.

Verification
REQ-036 Scenario 1, clean stream: generator seeded 0x01 drives bit_in with bit_vld=1 continuously.
-> locked=1 after 24 valid bits (8 fill + 16 matches).
-> after a further 1000 bits: err_cnt=0, bit_cnt=1000, lock_loss_cnt=0.
REQ-037 Scenario 2, single error: one bit_in inverted at locked bit 100.
-> err_cnt=1.
-> exactly one err_pulse, one cycle after that bit.
-> locked stays 1; subsequent bits error-free.
REQ-038 Scenario 3, burst: 8 consecutive inverted bits inside one window.
-> locked=0 on the 8th error edge, lock_loss_cnt=1, err_cnt=8.
-> relock after 24 further clean bits.
REQ-039 Scenario 4, constant zero: bit_in=0 from reset.
-> stuck_zero=1 after 8 bits.
-> locked never asserts; err_cnt=0.
-> a forced zero burst of 8 bits while LOCKED causes loss, lock_loss_cnt increments.
REQ-040 Scenario 5, clr collision: clr=1 on the same cycle as an error bit.
-> err_cnt=0 and bit_cnt=0 next cycle; locked unchanged.
-> the next error gives err_cnt=1.
REQ-041 Scenario 6, reset mid-lock and vld gaps:
-> rstb pulsed low while LOCKED asynchronously clears all outputs to their reset values; relock after 24 bits.
-> bit_vld toggled 1/0 every cycle gives the same counts as scenario 1, measured per valid bit.
